// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions: default payload width, NOP encoding and
// the valid-bit derived stage state encoding reused by other pipeline stages.
package pipe_pkg;
  localparam int          PIPE_WIDTH = 32;
  localparam logic [31:0] PIPE_NOP   = 32'h0000_0000;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  function automatic logic [1:0] pipe_state(input logic main_v, input logic skid_v);
    if (!main_v)     return ST_EMPTY;
    else if (skid_v) return ST_FULL;
    else             return ST_BUSY;
  endfunction
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter, falling-edge clocked, synchronous active-high reset.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  always_ff @(negedge clk) begin
    if (reset)
      count <= '0;
    else if (inc && (count != {CNT_W{1'b1}}))
      count <= count + 1'b1;
  end
endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline-stage register with valid/ready handshake, one-entry skid buffer,
// flush-to-bubble and a saturating stall counter. All state moves on negedge clk.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH      = PIPE_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL  = '0,
  parameter logic [WIDTH-1:0] BUBBLE_VAL = WIDTH'(PIPE_NOP),
  parameter int               CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] stall_cnt
);
  logic [WIDTH-1:0] main_d, main_d_n, skid_d, skid_d_n;
  logic             main_v, main_v_n, skid_v, skid_v_n;
  logic             in_ready_n;
  logic             in_xfer;
  logic [1:0]       st;

  assign st        = pipe_state(main_v, skid_v);
  assign in_xfer   = in_valid & in_ready;
  assign out_valid = main_v;
  assign out_data  = main_d;

  always_comb begin
    main_d_n = main_d;
    main_v_n = main_v;
    skid_d_n = skid_d;
    skid_v_n = skid_v;
    case (st)
      ST_EMPTY: begin
        if (in_xfer) begin
          main_d_n = in_data;
          main_v_n = 1'b1;
        end
      end
      ST_BUSY: begin
        if (out_ready && in_xfer) begin
          main_d_n = in_data;
        end else if (out_ready) begin
          main_v_n = 1'b0;
        end else if (in_xfer) begin
          skid_d_n = in_data;
          skid_v_n = 1'b1;
        end
      end
      ST_FULL: begin
        if (out_ready) begin
          main_d_n = skid_d;
          skid_v_n = 1'b0;
        end
      end
      default: ;
    endcase
    // Flush drops everything held, including a same-cycle input word.
    if (flush) begin
      main_d_n = BUBBLE_VAL;
      main_v_n = 1'b0;
      skid_v_n = 1'b0;
    end
    in_ready_n = !(main_v_n && skid_v_n);
  end

  always_ff @(negedge clk) begin
    if (reset) begin
      main_d   <= RESET_VAL;
      main_v   <= 1'b0;
      skid_d   <= '0;
      skid_v   <= 1'b0;
      in_ready <= 1'b1;
    end else begin
      main_d   <= main_d_n;
      main_v   <= main_v_n;
      skid_d   <= skid_d_n;
      skid_v   <= skid_v_n;
      in_ready <= in_ready_n;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (main_v & ~out_ready),
    .count (stall_cnt)
  );
endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed vector table, hand-written corner sequences,
// then randomized traffic against a queue-based reference model.
module tb_pipe_skid_reg;
  localparam logic [31:0] RST_V = 32'hDEAD_BEEF;
  localparam logic [31:0] BUB_V = 32'h0000_0013;

  logic        clk, reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data, out_data;
  logic [3:0]  stall_cnt;

  int checks = 0;
  int failures = 0;

  pipe_skid_reg #(.WIDTH(32), .RESET_VAL(RST_V), .BUBBLE_VAL(BUB_V), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  // Reference model: words held by the stage in arrival order.
  logic [31:0] m_q[$];
  logic [31:0] m_shown;
  int          m_cnt;

  task automatic model_edge(input logic r, input logic f, input logic iv,
                            input logic [31:0] d, input logic ord);
    logic rdy;
    if (r) begin
      m_q.delete();
      m_shown = RST_V;
      m_cnt   = 0;
    end else begin
      if (m_q.size() > 0 && !ord && m_cnt < 15) m_cnt++;
      rdy = (m_q.size() < 2);
      if (f) begin
        m_q.delete();
        m_shown = BUB_V;
      end else begin
        if (m_q.size() > 0 && ord) void'(m_q.pop_front());
        if (iv && rdy) m_q.push_back(d);
        if (m_q.size() > 0) m_shown = m_q[0];
      end
    end
  endtask

  task automatic step(input logic r, input logic f, input logic iv,
                      input logic [31:0] d, input logic ord);
    reset = r; flush = f; in_valid = iv; in_data = d; out_ready = ord;
    model_edge(r, f, iv, d, ord);
    @(negedge clk);
    @(posedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic ov, input logic [31:0] od,
                         input logic ir, input int cnt);
    chk({name, ".out_valid"}, {31'b0, out_valid}, {31'b0, ov});
    chk({name, ".out_data"},  out_data, od);
    chk({name, ".in_ready"},  {31'b0, in_ready}, {31'b0, ir});
    chk({name, ".stall_cnt"}, 32'(stall_cnt), 32'(cnt));
  endtask

  typedef struct {
    logic        rst, fl, iv;
    logic [31:0] d;
    logic        ord;
    logic        ov;
    logic [31:0] od;
    logic        ir;
    int          cnt;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic fl, input logic iv,
                              input logic [31:0] d, input logic ord, input logic ov,
                              input logic [31:0] od, input logic ir, input int cnt);
    vec_t v;
    v.rst = rst; v.fl = fl; v.iv = iv; v.d = d; v.ord = ord;
    v.ov = ov; v.od = od; v.ir = ir; v.cnt = cnt;
    return v;
  endfunction

  vec_t tbl[15];

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    m_shown = '0; m_cnt = 0;

    //          rst   fl    iv    data          ord   ov    out_data      ir    cnt
    tbl[0]  = mk(1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, RST_V,        1'b1, 0);
    tbl[1]  = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, RST_V,        1'b1, 0);
    tbl[2]  = mk(1'b0, 1'b0, 1'b1, 32'h10,       1'b1, 1'b1, 32'h10,       1'b1, 0);
    tbl[3]  = mk(1'b0, 1'b0, 1'b1, 32'h14,       1'b1, 1'b1, 32'h14,       1'b1, 0);
    tbl[4]  = mk(1'b0, 1'b0, 1'b1, 32'h18,       1'b1, 1'b1, 32'h18,       1'b1, 0);
    tbl[5]  = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h18,       1'b1, 0);
    tbl[6]  = mk(1'b0, 1'b0, 1'b1, 32'h20,       1'b0, 1'b1, 32'h20,       1'b1, 0);
    tbl[7]  = mk(1'b0, 1'b0, 1'b1, 32'h24,       1'b0, 1'b1, 32'h20,       1'b0, 1);
    tbl[8]  = mk(1'b0, 1'b0, 1'b1, 32'h99,       1'b0, 1'b1, 32'h20,       1'b0, 2);
    tbl[9]  = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h24,       1'b1, 2);
    tbl[10] = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h24,       1'b1, 2);
    tbl[11] = mk(1'b0, 1'b0, 1'b1, 32'h30,       1'b0, 1'b1, 32'h30,       1'b1, 2);
    tbl[12] = mk(1'b0, 1'b0, 1'b1, 32'h34,       1'b0, 1'b1, 32'h30,       1'b0, 3);
    tbl[13] = mk(1'b0, 1'b1, 1'b1, 32'h38,       1'b0, 1'b0, BUB_V,        1'b1, 4);
    tbl[14] = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, BUB_V,        1'b1, 4);

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].fl, tbl[i].iv, tbl[i].d, tbl[i].ord);
      chk_all($sformatf("vec%0d", i), tbl[i].ov, tbl[i].od, tbl[i].ir, tbl[i].cnt);
    end

    // Counter saturation: one word held under back-pressure for 20 edges.
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h40, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      chk($sformatf("sat%0d", k), 32'(stall_cnt), 32'((k < 15) ? k : 15));
    end
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    chk_all("sat_flush", 1'b0, BUB_V, 1'b1, 15);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    chk_all("sat_reset", 1'b0, RST_V, 1'b1, 0);

    // Reset and flush together in BUSY: reset values win.
    step(1'b0, 1'b0, 1'b1, 32'h50, 1'b0);
    step(1'b1, 1'b1, 1'b1, 32'h54, 1'b0);
    chk_all("rst_flush", 1'b0, RST_V, 1'b1, 0);

    // Reset in FULL discards both entries; nothing reappears afterwards.
    step(1'b0, 1'b0, 1'b1, 32'h60, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h64, 1'b0);
    chk_all("full_pre", 1'b1, 32'h60, 1'b0, 1);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk_all("full_rst", 1'b0, RST_V, 1'b1, 0);

    // Randomized traffic against the queue model.
    for (int n = 0; n < 400; n++) begin
      logic r, f, iv, ord;
      r   = ($urandom_range(0, 59) == 0);
      f   = ($urandom_range(0, 19) == 0);
      iv  = ($urandom_range(0, 99) < 60);
      ord = ($urandom_range(0, 99) < 55);
      step(r, f, iv, $urandom, ord);
      chk_all($sformatf("rnd%0d", n), (m_q.size() > 0), m_shown, (m_q.size() < 2), m_cnt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
